// File: rtl/eeg_fram_agent_pkg.sv
// eeg_fram_agent_pkg
// Shared definitions for the FRAM lane initiator: default parameter widths
// and the one-hot FSM state encoding.
package eeg_fram_agent_pkg;

    localparam int FRAM_ADD_AW_DEF = 12;
    localparam int FRAM_DAT_DW_DEF = 4;
    localparam int FRAM_LEN_DW_DEF = 10;
    localparam int RBUF_DEPTH_DEF  = 4;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_WRITE = 4'b0010,
        ST_READ  = 4'b0100,
        ST_DRAIN = 4'b1000
    } state_e;

endpackage

// File: rtl/eeg_fram_agent_rbuf.sv
// eeg_fram_agent_rbuf
// Synchronous FIFO holding returned read beats ({lst, dat}). No fall-through:
// a pushed entry becomes visible at the head on the following cycle. Push and
// pop in the same cycle are legal, including when full (the head is read
// before the slot is overwritten).
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   push_i/push_dat_i  write strobe and entry (caller guarantees space)
//   pop_i          remove head entry (ignored when empty)
//   head_o         current head entry
//   empty_o/full_o occupancy flags
module eeg_fram_agent_rbuf #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW:0]      wr_ptr_q;
    logic [PW:0]      rd_ptr_q;
    logic             do_pop_s;

    // Extra pointer MSB distinguishes full from empty when indices match.
    assign empty_o  = (wr_ptr_q == rd_ptr_q);
    assign full_o   = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                      (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign do_pop_s = pop_i & ~empty_o;
    assign head_o   = mem_q[rd_ptr_q[PW-1:0]];

    // Pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

    // Storage array; contents need no reset because empty_o masks them.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q[PW-1:0]] <= push_dat_i;
        end
    end

endmodule

// File: rtl/eeg_fram_agent.sv
// eeg_fram_agent
// Engine-side initiator for one FRAM lane. A command (write/read, base
// address, beats-1) becomes either an ETOF_DAT write stream fed from SRC or
// an ETOF_ADD address stream. Read data on FTOE_DAT is always accepted
// (the lane cannot be back-pressured) into a return buffer, and issuing of
// read addresses is credit-limited so that buffer can never overflow.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   IS_IDLE                  FSM in IDLE
//   CMD_*                    command handshake and fields
//   SRC_*                    write-data source
//   ETOF_DAT_*               write beats to FRAM
//   ETOF_ADD_*               read addresses to FRAM
//   FTOE_DAT_*               read data from FRAM
//   SNK_*                    forwarded read data
//   DONE                     one-cycle pulse on burst completion
//   ERR                      sticky protocol error
// Optional feature: define EEG_FRAM_AGENT_CHK_EN to build the response
// checker (unsolicited beat / LST mismatch detection); otherwise ERR is 0.
module eeg_fram_agent
    import eeg_fram_agent_pkg::*;
#(
    parameter int FRAM_ADD_AW = FRAM_ADD_AW_DEF,
    parameter int FRAM_DAT_DW = FRAM_DAT_DW_DEF,
    parameter int FRAM_LEN_DW = FRAM_LEN_DW_DEF,
    parameter int RBUF_DEPTH  = RBUF_DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   IS_IDLE,
    input  logic                   CMD_VLD,
    output logic                   CMD_RDY,
    input  logic                   CMD_WR,
    input  logic [FRAM_ADD_AW-1:0] CMD_ADD,
    input  logic [FRAM_LEN_DW-1:0] CMD_LEN,
    input  logic                   SRC_VLD,
    output logic                   SRC_RDY,
    input  logic [FRAM_DAT_DW-1:0] SRC_DAT,
    output logic                   ETOF_DAT_VLD,
    output logic                   ETOF_DAT_LST,
    input  logic                   ETOF_DAT_RDY,
    output logic [FRAM_ADD_AW-1:0] ETOF_DAT_ADD,
    output logic [FRAM_DAT_DW-1:0] ETOF_DAT_DAT,
    output logic                   ETOF_ADD_VLD,
    output logic                   ETOF_ADD_LST,
    input  logic                   ETOF_ADD_RDY,
    output logic [FRAM_ADD_AW-1:0] ETOF_ADD_ADD,
    input  logic                   FTOE_DAT_VLD,
    input  logic                   FTOE_DAT_LST,
    output logic                   FTOE_DAT_RDY,
    input  logic [FRAM_DAT_DW-1:0] FTOE_DAT_DAT,
    output logic                   SNK_VLD,
    output logic                   SNK_LST,
    input  logic                   SNK_RDY,
    output logic [FRAM_DAT_DW-1:0] SNK_DAT,
    output logic                   DONE,
    output logic                   ERR
);
    localparam int CW = $clog2(RBUF_DEPTH) + 1;
    localparam logic [CW-1:0]          CRED_MAX = CW'(RBUF_DEPTH);
    localparam logic [CW-1:0]          CRED_ONE = CW'(1);
    localparam logic [FRAM_LEN_DW-1:0] BEAT_ONE = FRAM_LEN_DW'(1);

    // The burst direction is carried by the WRITE/READ state itself.
    state_e                 state_q, state_d;
    logic [FRAM_ADD_AW-1:0] add_q, add_d;
    logic [FRAM_LEN_DW-1:0] len_q, len_d;
    logic [FRAM_LEN_DW-1:0] beat_q, beat_d;
    logic [CW-1:0]          credit_q, credit_d;
    logic                   ftoe_rdy_q;

    logic                   cmd_acc_s, wr_acc_s, ad_acc_s, snk_acc_s;
    logic                   ftoe_hs_s, is_lst_s, credit_ok_s;
    logic [FRAM_ADD_AW-1:0] cur_add_s;
    logic                   rb_empty_s, rb_full_s, rb_push_s;
    logic [FRAM_DAT_DW:0]   rb_head_s;

    assign cmd_acc_s   = CMD_VLD & (state_q == ST_IDLE);
    assign credit_ok_s = (credit_q != '0);
    assign wr_acc_s    = (state_q == ST_WRITE) & SRC_VLD & ETOF_DAT_RDY;
    assign ad_acc_s    = (state_q == ST_READ) & credit_ok_s & ETOF_ADD_RDY;
    assign snk_acc_s   = ~rb_empty_s & SNK_RDY;
    assign ftoe_hs_s   = FTOE_DAT_VLD & ftoe_rdy_q;
    // Address wraps modulo 2^FRAM_ADD_AW by truncation.
    assign cur_add_s   = add_q + FRAM_ADD_AW'(beat_q);
    assign is_lst_s    = (beat_q == len_q);

    // Space is guaranteed by credits; the guard only protects the FIFO.
    assign rb_push_s = ftoe_hs_s & (~rb_full_s | snk_acc_s);

    eeg_fram_agent_rbuf #(
        .DEPTH (RBUF_DEPTH),
        .WIDTH (FRAM_DAT_DW + 1)
    ) u_rbuf (
        .clk        (clk),
        .rst        (rst),
        .push_i     (rb_push_s),
        .push_dat_i ({FTOE_DAT_LST, FTOE_DAT_DAT}),
        .pop_i      (snk_acc_s),
        .head_o     (rb_head_s),
        .empty_o    (rb_empty_s),
        .full_o     (rb_full_s)
    );

    assign IS_IDLE      = (state_q == ST_IDLE);
    assign CMD_RDY      = (state_q == ST_IDLE);
    assign FTOE_DAT_RDY = ftoe_rdy_q;
    assign SNK_VLD      = ~rb_empty_s;
    assign SNK_LST      = rb_empty_s ? 1'b0 : rb_head_s[FRAM_DAT_DW];
    assign SNK_DAT      = rb_empty_s ? '0 : rb_head_s[FRAM_DAT_DW-1:0];
    assign DONE         = (wr_acc_s & is_lst_s) |
                          ((state_q == ST_DRAIN) & snk_acc_s & SNK_LST);

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_acc_s) state_d = CMD_WR ? ST_WRITE : ST_READ;
                else           state_d = ST_IDLE;
            end
            ST_WRITE: begin
                if (wr_acc_s & is_lst_s) state_d = ST_IDLE;
                else                     state_d = ST_WRITE;
            end
            ST_READ: begin
                if (ad_acc_s & is_lst_s) state_d = ST_DRAIN;
                else                     state_d = ST_READ;
            end
            ST_DRAIN: begin
                if (snk_acc_s & SNK_LST) state_d = ST_IDLE;
                else                     state_d = ST_DRAIN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FRAM-side outputs; the idle mode's channel is held at zero.
    always_comb begin
        SRC_RDY      = 1'b0;
        ETOF_DAT_VLD = 1'b0;
        ETOF_DAT_LST = 1'b0;
        ETOF_DAT_ADD = '0;
        ETOF_DAT_DAT = '0;
        ETOF_ADD_VLD = 1'b0;
        ETOF_ADD_LST = 1'b0;
        ETOF_ADD_ADD = '0;
        case (state_q)
            ST_WRITE: begin
                SRC_RDY      = ETOF_DAT_RDY;
                ETOF_DAT_VLD = SRC_VLD;
                ETOF_DAT_LST = is_lst_s;
                ETOF_DAT_ADD = cur_add_s;
                ETOF_DAT_DAT = SRC_DAT;
            end
            ST_READ: begin
                ETOF_ADD_VLD = credit_ok_s;
                ETOF_ADD_LST = is_lst_s;
                ETOF_ADD_ADD = cur_add_s;
            end
            default: SRC_RDY = 1'b0;
        endcase
    end

    // Command capture, beat counter and credit update.
    always_comb begin
        add_d    = add_q;
        len_d    = len_q;
        beat_d   = beat_q;
        credit_d = credit_q;
        if (cmd_acc_s) begin
            add_d  = CMD_ADD;
            len_d  = CMD_LEN;
            beat_d = '0;
        end else if (wr_acc_s | ad_acc_s) begin
            beat_d = beat_q + BEAT_ONE;
        end else begin
            beat_d = beat_q;
        end
        case ({ad_acc_s, snk_acc_s})
            2'b10:   credit_d = credit_q - CRED_ONE;
            2'b01:   credit_d = credit_q + CRED_ONE;
            default: credit_d = credit_q;
        endcase
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            add_q      <= '0;
            len_q      <= '0;
            beat_q     <= '0;
            credit_q   <= CRED_MAX;
            ftoe_rdy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            add_q      <= add_d;
            len_q      <= len_d;
            beat_q     <= beat_d;
            credit_q   <= credit_d;
            ftoe_rdy_q <= 1'b1;
        end
    end

`ifdef EEG_FRAM_AGENT_CHK_EN
    // Outstanding addresses and their LST flags, oldest at bit 0.
    logic [CW-1:0]         out_q, out_d, out_pop_s;
    logic [RBUF_DEPTH-1:0] lst_q, lst_d;
    logic                  err_q, err_d, chk_pop_s;

    assign chk_pop_s = ftoe_hs_s & (out_q != '0);
    assign out_pop_s = out_q - {{(CW-1){1'b0}}, chk_pop_s};
    assign ERR       = err_q;

    // Checker next-state: retire the oldest flag, append a newly issued one.
    always_comb begin
        err_d = err_q;
        lst_d = chk_pop_s ? (lst_q >> 1) : lst_q;
        out_d = out_pop_s;
        if (ftoe_hs_s && (out_q == '0)) begin
            err_d = 1'b1;
        end else if (chk_pop_s && (FTOE_DAT_LST != lst_q[0])) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
        if (ad_acc_s) begin
            lst_d[out_pop_s[CW-2:0]] = ETOF_ADD_LST;
            out_d = out_pop_s + CRED_ONE;
        end else begin
            out_d = out_pop_s;
        end
    end

    // Checker registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
            lst_q <= '0;
            err_q <= 1'b0;
        end else begin
            out_q <= out_d;
            lst_q <= lst_d;
            err_q <= err_d;
        end
    end
`else
    assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_eeg_fram_agent.sv
module tb_eeg_fram_agent;

    typedef struct packed {
        logic [11:0] a;
        logic [3:0]  d;
        logic        l;
    } beat_t;

    typedef struct packed {
        int         due;
        logic [3:0] d;
        logic       l;
    } ret_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        IS_IDLE, CMD_VLD, CMD_RDY, CMD_WR;
    logic [11:0] CMD_ADD;
    logic [9:0]  CMD_LEN;
    logic        SRC_VLD, SRC_RDY;
    logic [3:0]  SRC_DAT;
    logic        ETOF_DAT_VLD, ETOF_DAT_LST, ETOF_DAT_RDY;
    logic [11:0] ETOF_DAT_ADD;
    logic [3:0]  ETOF_DAT_DAT;
    logic        ETOF_ADD_VLD, ETOF_ADD_LST, ETOF_ADD_RDY;
    logic [11:0] ETOF_ADD_ADD;
    logic        FTOE_DAT_VLD, FTOE_DAT_LST, FTOE_DAT_RDY;
    logic [3:0]  FTOE_DAT_DAT;
    logic        SNK_VLD, SNK_LST, SNK_RDY;
    logic [3:0]  SNK_DAT;
    logic        DONE, ERR;

    always #5 clk = ~clk;

    eeg_fram_agent dut (
        .clk(clk), .rst(rst), .IS_IDLE(IS_IDLE),
        .CMD_VLD(CMD_VLD), .CMD_RDY(CMD_RDY), .CMD_WR(CMD_WR),
        .CMD_ADD(CMD_ADD), .CMD_LEN(CMD_LEN),
        .SRC_VLD(SRC_VLD), .SRC_RDY(SRC_RDY), .SRC_DAT(SRC_DAT),
        .ETOF_DAT_VLD(ETOF_DAT_VLD), .ETOF_DAT_LST(ETOF_DAT_LST),
        .ETOF_DAT_RDY(ETOF_DAT_RDY), .ETOF_DAT_ADD(ETOF_DAT_ADD),
        .ETOF_DAT_DAT(ETOF_DAT_DAT),
        .ETOF_ADD_VLD(ETOF_ADD_VLD), .ETOF_ADD_LST(ETOF_ADD_LST),
        .ETOF_ADD_RDY(ETOF_ADD_RDY), .ETOF_ADD_ADD(ETOF_ADD_ADD),
        .FTOE_DAT_VLD(FTOE_DAT_VLD), .FTOE_DAT_LST(FTOE_DAT_LST),
        .FTOE_DAT_RDY(FTOE_DAT_RDY), .FTOE_DAT_DAT(FTOE_DAT_DAT),
        .SNK_VLD(SNK_VLD), .SNK_LST(SNK_LST), .SNK_RDY(SNK_RDY),
        .SNK_DAT(SNK_DAT), .DONE(DONE), .ERR(ERR)
    );

    // All outputs in one vector for reset-value checks.
    logic [43:0] outv;
    assign outv = {IS_IDLE, CMD_RDY, SRC_RDY, ETOF_DAT_VLD, ETOF_DAT_LST,
                   ETOF_DAT_ADD, ETOF_DAT_DAT, ETOF_ADD_VLD, ETOF_ADD_LST,
                   ETOF_ADD_ADD, FTOE_DAT_RDY, SNK_VLD, SNK_LST, SNK_DAT,
                   DONE, ERR};
    localparam logic [43:0] RST_VEC = {2'b11, 42'd0};

    beat_t      exp_wr[$];
    beat_t      exp_add[$];
    beat_t      exp_snk[$];
    ret_t       ret_q[$];
    logic [3:0] src_q[$];

    int n_chk = 0, n_pass = 0, cyc = 0, n_addr = 0, n_ftoe = 0;
    int done_cnt = 0, exp_dn = 0;
    bit chk_ftoe = 1'b0, tog_mode = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Source and FRAM drivers: update just after each rising edge.
    initial begin
        SRC_VLD = 1'b0; SRC_DAT = 4'h0; ETOF_DAT_RDY = 1'b1;
        FTOE_DAT_VLD = 1'b0; FTOE_DAT_LST = 1'b0; FTOE_DAT_DAT = 4'h0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (src_q.size() > 0) begin
                SRC_VLD = 1'b1; SRC_DAT = src_q[0];
            end else begin
                SRC_VLD = 1'b0; SRC_DAT = 4'h0;
            end
            ETOF_DAT_RDY = tog_mode ? ~ETOF_DAT_RDY : 1'b1;
            if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
                ret_t r;
                r = ret_q.pop_front();
                FTOE_DAT_VLD = 1'b1; FTOE_DAT_LST = r.l; FTOE_DAT_DAT = r.d;
            end else begin
                FTOE_DAT_VLD = 1'b0; FTOE_DAT_LST = 1'b0; FTOE_DAT_DAT = 4'h0;
            end
        end
    end

    // Monitor: compares every handshake against the scoreboard queues.
    always @(negedge clk) begin
        if (!rst) begin
            logic  wr_hs, ad_hs, snk_hs, exp_done;
            beat_t e;
            ret_t  r;
            wr_hs    = ETOF_DAT_VLD & ETOF_DAT_RDY;
            ad_hs    = ETOF_ADD_VLD & ETOF_ADD_RDY;
            snk_hs   = SNK_VLD & SNK_RDY;
            exp_done = 1'b0;
            if (ETOF_DAT_VLD) chk("src_rdy_mirror", SRC_RDY, ETOF_DAT_RDY);
            if (chk_ftoe) chk("ftoe_rdy", FTOE_DAT_RDY, 1'b1);
            if (FTOE_DAT_VLD & FTOE_DAT_RDY) n_ftoe++;
            if (wr_hs) begin
                if (src_q.size() > 0) void'(src_q.pop_front());
                if (exp_wr.size() == 0) begin
                    n_chk++;
                    $display("FAIL wr_unexp: beat addr %0h with none expected", ETOF_DAT_ADD);
                end else begin
                    e = exp_wr.pop_front();
                    chk("wr_beat", {ETOF_DAT_ADD, ETOF_DAT_DAT, ETOF_DAT_LST}, e);
                    exp_done = e.l;
                end
            end
            if (ad_hs) begin
                n_addr++;
                r.due = cyc + 4; r.d = ETOF_ADD_ADD[3:0] ^ 4'hA; r.l = ETOF_ADD_LST;
                ret_q.push_back(r);
                if (exp_add.size() == 0) begin
                    n_chk++;
                    $display("FAIL add_unexp: addr %0h with none expected", ETOF_ADD_ADD);
                end else begin
                    e = exp_add.pop_front();
                    chk("rd_addr", {ETOF_ADD_ADD, 4'h0, ETOF_ADD_LST}, e);
                end
            end
            if (snk_hs) begin
                if (exp_snk.size() == 0) begin
                    n_chk++;
                    $display("FAIL snk_unexp: data %0h with none expected", SNK_DAT);
                end else begin
                    e = exp_snk.pop_front();
                    chk("snk_beat", {SNK_DAT, SNK_LST}, {e.d, e.l});
                    exp_done = exp_done | e.l;
                end
            end
            if (wr_hs | snk_hs | DONE) chk("done_pulse", DONE, exp_done);
            if (DONE) done_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic push_wr(input logic [11:0] a, input logic [3:0] d, input logic l);
        beat_t e;
        e.a = a; e.d = d; e.l = l;
        exp_wr.push_back(e);
        src_q.push_back(d);
    endtask

    task automatic push_rd(input logic [11:0] a, input int len);
        beat_t e;
        for (int i = 0; i <= len; i++) begin
            e.a = a + 12'(i); e.d = 4'h0; e.l = (i == len);
            exp_add.push_back(e);
            e.d = e.a[3:0] ^ 4'hA;
            exp_snk.push_back(e);
        end
    endtask

    task automatic send_cmd(input logic wr, input logic [11:0] a, input logic [9:0] l);
        int k = 0;
        CMD_VLD = 1'b1; CMD_WR = wr; CMD_ADD = a; CMD_LEN = l;
        @(negedge clk);
        while (!CMD_RDY && k < 50) begin @(negedge clk); k++; end
        chk("cmd_accept", CMD_RDY, 1'b1);
        @(posedge clk); #1;
        CMD_VLD = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int k = 0;
        while (done_cnt < exp_dn && k < bound) begin @(posedge clk); #1; k++; end
        chk("done_count", done_cnt, exp_dn);
    endtask

    task automatic do_reset();
        rst = 1'b1; CMD_VLD = 1'b0; SNK_RDY = 1'b0; tog_mode = 1'b0; chk_ftoe = 1'b0;
        exp_wr.delete(); exp_add.delete(); exp_snk.delete(); ret_q.delete(); src_q.delete();
        @(posedge clk);
        @(negedge clk);
        chk("rst_outputs_during", outv, RST_VEC);
        @(posedge clk); #1;
        rst = 1'b0;
        ret_q.delete();
        @(negedge clk);
        chk("rst_outputs_after", outv, RST_VEC);
        @(posedge clk); #1;
    endtask

    initial begin
        int n0;
        int k;
        rst = 1'b1; CMD_VLD = 1'b0; CMD_WR = 1'b0; CMD_ADD = 12'h0; CMD_LEN = 10'd0;
        SNK_RDY = 1'b0; ETOF_ADD_RDY = 1'b1;
        tick(2);
        do_reset();

        // Write burst crossing the top of the address space.
        push_wr(12'hFFE, 4'hC, 1'b0);
        push_wr(12'hFFF, 4'h3, 1'b0);
        push_wr(12'h000, 4'h9, 1'b0);
        push_wr(12'h001, 4'h6, 1'b1);
        tick(1);
        exp_dn++;
        send_cmd(1'b1, 12'hFFE, 10'd3);
        @(negedge clk);
        chk("first_beat_next_cycle", ETOF_DAT_VLD, 1'b1);
        wait_done(50);

        // Write burst with ETOF_DAT_RDY toggling.
        for (int i = 0; i < 6; i++) push_wr(12'h010 + 12'(i), 4'(i + 1), i == 5);
        tog_mode = 1'b1;
        exp_dn++;
        send_cmd(1'b1, 12'h010, 10'd5);
        wait_done(100);
        tog_mode = 1'b0;

        // Read burst with sink stalled: credit caps issued addresses at 4.
        push_rd(12'h100, 7);
        chk_ftoe = 1'b1;
        n0 = n_addr;
        exp_dn++;
        send_cmd(1'b0, 12'h100, 10'd7);
        tick(20);
        chk("addr_credit_limit", n_addr - n0, 4);
        SNK_RDY = 1'b1;
        wait_done(200);
        chk_ftoe = 1'b0;

        // Single-beat read.
        push_rd(12'h7FF, 0);
        exp_dn++;
        send_cmd(1'b0, 12'h7FF, 10'd0);
        wait_done(50);
        chk("queues_drained", exp_wr.size() + exp_add.size() + exp_snk.size(), 0);

        // Reset in mid-read with beats in the return buffer.
        SNK_RDY = 1'b0;
        push_rd(12'h200, 7);
        send_cmd(1'b0, 12'h200, 10'd7);
        n0 = n_ftoe; k = 0;
        while (n_ftoe - n0 < 2 && k < 50) begin tick(1); k++; end
        chk("two_beats_returned", (n_ftoe - n0 >= 2), 1'b1);
        do_reset();
        chk("no_done_on_reset", done_cnt, exp_dn);

        // Full credit after reset: exactly 4 addresses with a stalled sink.
        push_rd(12'h300, 7);
        n0 = n_addr;
        exp_dn++;
        send_cmd(1'b0, 12'h300, 10'd7);
        tick(20);
        chk("credit_after_reset", n_addr - n0, 4);
        SNK_RDY = 1'b1;
        wait_done(200);

        // Write completes normally after reset.
        push_wr(12'h0AB, 4'h7, 1'b0);
        push_wr(12'h0AC, 4'h8, 1'b1);
        exp_dn++;
        send_cmd(1'b1, 12'h0AB, 10'd1);
        wait_done(50);
        chk("queues_drained_end", exp_wr.size() + exp_add.size() + exp_snk.size(), 0);
        chk("err_clear", ERR, 1'b0);

`ifdef EEG_FRAM_AGENT_CHK_EN
        // Unsolicited FTOE beat while idle raises a sticky ERR.
        begin
            ret_t r;
            SNK_RDY = 1'b0;
            r.due = 0; r.d = 4'h3; r.l = 1'b1;
            ret_q.push_back(r);
            tick(3);
            @(negedge clk);
            chk("err_unsolicited", ERR, 1'b1);
            tick(5);
            @(negedge clk);
            chk("err_sticky", ERR, 1'b1);
            @(posedge clk); #1;
            do_reset();
            @(negedge clk);
            chk("err_cleared_by_rst", ERR, 1'b0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
